// File: rtl/ram_arbiter.sv
// Round-robin arbiter between two requesters sharing one single-port RAM.
// It latches one request at a time and returns read data with a per-requester valid strobe.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_write_en,
  output logic              ram_read_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [1:0] {StIdle, StAccess, StReadWait} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic                id_b_q, id_b_d;
  logic                last_b_q, last_b_d;
  logic                gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic                rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ram_we_q, ram_we_d, ram_re_q, ram_re_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                win_b;
  logic                sel_we;

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    id_b_d     = id_b_q;
    last_b_d   = last_b_q;
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    rvalid_a_d = 1'b0;
    rvalid_b_d = 1'b0;
    rdata_d    = rdata_q;
    ram_we_d   = 1'b0;
    ram_re_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    // B wins when it is alone, or on a tie when A was served last.
    win_b      = req_b & (~req_a | ~last_b_q);
    sel_we     = win_b ? we_b : we_a;

    unique case (state_q)
      StIdle: begin
        if (req_a || req_b) begin
          id_b_d     = win_b;
          last_b_d   = win_b;
          gnt_a_d    = ~win_b;
          gnt_b_d    = win_b;
          we_d       = sel_we;
          ram_addr_d = win_b ? addr_b : addr_a;
          ram_din_d  = win_b ? wdata_b : wdata_a;
          // Enables are registered here so they appear in the access cycle.
          ram_we_d   = sel_we;
          ram_re_d   = ~sel_we;
          state_d    = StAccess;
        end
      end
      StAccess: begin
        state_d = we_q ? StIdle : StReadWait;
      end
      StReadWait: begin
        rdata_d    = ram_data_out;
        rvalid_a_d = ~id_b_q;
        rvalid_b_d = id_b_q;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      id_b_q     <= 1'b0;
      last_b_q   <= 1'b1;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rdata_q    <= '0;
      ram_we_q   <= 1'b0;
      ram_re_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      id_b_q     <= id_b_d;
      last_b_q   <= last_b_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      rdata_q    <= rdata_d;
      ram_we_q   <= ram_we_d;
      ram_re_q   <= ram_re_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
    end
  end

  assign gnt_a        = gnt_a_q;
  assign gnt_b        = gnt_b_q;
  assign rvalid_a     = rvalid_a_q;
  assign rvalid_b     = rvalid_b_q;
  assign rdata        = rdata_q;
  assign ram_write_en = ram_we_q;
  assign ram_read_en  = ram_re_q;
  assign ram_addr     = ram_addr_q;
  assign ram_data_in  = ram_din_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed and random requests against a transaction-level timing model,
// with a behavioural single-port RAM attached to the RAM-side ports.
module tb_ram_arbiter;

  typedef struct packed {
    logic        we;
    logic [8:0]  addr;
    logic [15:0] data;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [8:0]  addr_a = '0, addr_b = '0;
  logic [15:0] wdata_a = '0, wdata_b = '0;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [15:0] rdata;
  logic        ram_write_en, ram_read_en;
  logic [8:0]  ram_addr;
  logic [15:0] ram_data_in;
  logic [15:0] ram_data_out = '0;

  logic [15:0] env_mem [512];

  ram_arbiter #(.ADDR_W(9), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b),
    .rdata(rdata),
    .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Single-port RAM: registered read data, one clock after read_en is sampled.
  always @(posedge clk) begin
    if (ram_write_en) env_mem[ram_addr] <= ram_data_in;
    if (ram_read_en)  ram_data_out <= env_mem[ram_addr];
  end

  // Reference model: pending requests, memory contents and expected outputs.
  req_t        qa[$], qb[$];
  logic [15:0] ref_mem [512];
  bit          last_b;
  int          wait_cnt, rd_cnt;
  bit          rd_b;
  logic [15:0] rd_val;
  logic        e_gnt_a, e_gnt_b, e_rva, e_rvb, e_we, e_re;
  logic [8:0]  e_addr;
  logic [15:0] e_din, e_rdata;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive();
    req_a = (qa.size() != 0);
    if (req_a) begin
      we_a = qa[0].we; addr_a = qa[0].addr; wdata_a = qa[0].data;
    end
    req_b = (qb.size() != 0);
    if (req_b) begin
      we_b = qb[0].we; addr_b = qb[0].addr; wdata_b = qb[0].data;
    end
  endtask

  task automatic model_edge(input logic s_rst);
    bit   pa, pb, wb;
    req_t r;
    pa = (qa.size() != 0);
    pb = (qb.size() != 0);
    e_gnt_a = 0; e_gnt_b = 0; e_rva = 0; e_rvb = 0; e_we = 0; e_re = 0;
    if (s_rst) begin
      last_b = 1; wait_cnt = 0; rd_cnt = 0;
      e_addr = '0; e_din = '0; e_rdata = '0;
    end else begin
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          e_rdata = rd_val;
          if (rd_b) e_rvb = 1; else e_rva = 1;
        end
      end
      if (wait_cnt > 0) wait_cnt--;
      else if (pa || pb) begin
        wb = (pa && pb) ? !last_b : pb;
        last_b = wb;
        if (wb) begin r = qb.pop_front(); e_gnt_b = 1; end
        else begin r = qa.pop_front(); e_gnt_a = 1; end
        e_we = r.we; e_re = !r.we; e_addr = r.addr; e_din = r.data;
        if (r.we) begin
          ref_mem[r.addr] = r.data;
          wait_cnt = 1;
        end else begin
          rd_val = ref_mem[r.addr]; rd_b = wb; rd_cnt = 2; wait_cnt = 2;
        end
      end
    end
  endtask

  task automatic step();
    logic s_rst;
    drive();
    s_rst = rst;
    model_edge(s_rst);
    @(posedge clk);
    #1;
    chk("gnt_a", 32'(gnt_a), 32'(e_gnt_a));
    chk("gnt_b", 32'(gnt_b), 32'(e_gnt_b));
    chk("rvalid_a", 32'(rvalid_a), 32'(e_rva));
    chk("rvalid_b", 32'(rvalid_b), 32'(e_rvb));
    chk("ram_write_en", 32'(ram_write_en), 32'(e_we));
    chk("ram_read_en", 32'(ram_read_en), 32'(e_re));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("ram_data_in", 32'(ram_data_in), 32'(e_din));
    chk("rdata", 32'(rdata), 32'(e_rdata));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic req_t mk(input logic we, input int addr, input int data);
    req_t r;
    r.we = we; r.addr = 9'(addr); r.data = 16'(data);
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 512; i++) begin
      env_mem[i] = '0;
      ref_mem[i] = '0;
    end
    last_b = 1; wait_cnt = 0; rd_cnt = 0; rd_b = 0; rd_val = '0;
    e_addr = '0; e_din = '0; e_rdata = '0;

    // Reset held two cycles, then idle.
    rst = 1;
    run(2);
    rst = 0;
    run(3);

    // A writes addr 1 = 1, then reads it back.
    qa.push_back(mk(1, 1, 1));
    run(3);
    qa.push_back(mk(0, 1, 0));
    run(5);

    // Contention from reset: A wins first, B two cycles later; B reads back addr 3.
    rst = 1;
    run(1);
    rst = 0;
    qa.push_back(mk(1, 2, 4));
    qb.push_back(mk(1, 3, 8));
    run(5);
    qb.push_back(mk(0, 3, 0));
    run(5);

    // Continuous requests from both sides with alternating addresses.
    for (int i = 0; i < 6; i++) begin
      qa.push_back(mk(1, 16 + 2 * i, 16'h100 + i));
      qb.push_back(mk(1, 17 + 2 * i, 16'h200 + i));
    end
    run(26);

    // B reads addr 2 while A's request is pending behind it.
    qb.push_back(mk(0, 2, 0));
    run(1);
    qa.push_back(mk(0, 1, 0));
    run(7);

    // Reset during READ_WAIT abandons the read; the next read is normal.
    qa.push_back(mk(0, 1, 0));
    run(2);
    rst = 1;
    run(1);
    rst = 0;
    run(2);
    qa.push_back(mk(0, 1, 0));
    run(5);

    // Random traffic over a small address range so reads hit earlier writes.
    for (int c = 0; c < 150; c++) begin
      if (qa.size() == 0 && ($urandom % 2) == 1)
        qa.push_back(mk(1'($urandom % 2), int'($urandom_range(0, 7)), int'($urandom)));
      if (qb.size() == 0 && ($urandom % 3) == 0)
        qb.push_back(mk(1'($urandom % 2), int'($urandom_range(0, 7)), int'($urandom)));
      step();
    end
    run(12);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
